// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage scalar/vector pipeline.
// It produces the stage-register enables, the IF/ID flush and the ID/EX bubble.
// It produces the operand forwarding selects for both sources.
// It runs the req/ack sequencer that freezes the pipeline while a 128-bit
// memory access is outstanding.
// It keeps a sticky timeout flag and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_rs1_vf,
  input  logic             id_rs2_vf,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [3:0]       ex_dest,
  input  logic             ex_vf,
  input  logic             ex_wreg,
  input  logic             ex_rmem,
  input  logic             ex_br_taken,
  input  logic [3:0]       mem_dest,
  input  logic             mem_vf,
  input  logic             mem_wreg,
  input  logic             mem_rmem,
  input  logic             mem_wmem,
  input  logic [3:0]       wb_dest,
  input  logic             wb_vf,
  input  logic             wb_wreg,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mstate_e;

  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  mstate_e          state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic freeze_s;
  logic load_use_s;
  logic mem_op_s;

  // Producer in stage X writes the register that source S reads.
  // Scalar R0 is hard-wired zero, so it is never forwarded or stalled on.
  // Vector V0 is a real register and does match.
  function automatic logic src_match(input logic [3:0] s, input logic s_vf, input logic s_use,
                                     input logic [3:0] x_dest, input logic x_vf,
                                     input logic x_wreg);
    return s_use & x_wreg & (x_dest == s) & (x_vf == s_vf) & ~(~s_vf & (s == 4'd0));
  endfunction

  assign mem_op_s   = mem_rmem | mem_wmem;
  assign freeze_s   = (state_q == M_WAIT) | ((state_q == M_IDLE) & mem_op_s);
  assign load_use_s = ex_rmem &
                      (src_match(id_rs1, id_rs1_vf, id_rs1_use, ex_dest, ex_vf, ex_wreg) |
                       src_match(id_rs2, id_rs2_vf, id_rs2_use, ex_dest, ex_vf, ex_wreg));
  assign mem_req      = (state_q == M_WAIT);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

  // Memory sequencer next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      M_IDLE: begin
        if (mem_op_s) begin
          state_d = M_WAIT;
        end else begin
          state_d = M_IDLE;
        end
      end
      M_WAIT: begin
        if (mem_ack) begin
          state_d    = M_DONE;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abort: the instruction retires with an undefined result.
          mem_err_d  = 1'b1;
          state_d    = M_DONE;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      M_DONE: begin
        state_d = M_IDLE;
      end
      default: begin
        state_d    = M_IDLE;
        wait_cnt_d = 16'd0;
      end
    endcase
  end

  // The stall counter counts freeze cycles and load-use stalls, and saturates.
  // A load-use stall hidden by a taken branch is not counted.
  always_comb begin
    if ((freeze_s | (load_use_s & ~ex_br_taken)) && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= M_IDLE;
      wait_cnt_q <= 16'd0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
    end
  end

  // Stage control: freeze overrides branch, and branch overrides load-use.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_en = 1'b1;
    end else if (freeze_s) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use_s) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      idex_bubble = 1'b0;
    end
  end

  // Forwarding selects: EX/MEM ALU result has priority over the MEM/WB result.
  // A load in MEM has no result yet, so it cannot be forwarded from EX/MEM.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      fwd_a = 2'b00;
    end else begin
      if (src_match(id_rs1, id_rs1_vf, id_rs1_use, mem_dest, mem_vf, mem_wreg) && !mem_rmem) begin
        fwd_a = 2'b01;
      end else if (src_match(id_rs1, id_rs1_vf, id_rs1_use, wb_dest, wb_vf, wb_wreg)) begin
        fwd_a = 2'b10;
      end else begin
        fwd_a = 2'b00;
      end
      if (src_match(id_rs2, id_rs2_vf, id_rs2_use, mem_dest, mem_vf, mem_wreg) && !mem_rmem) begin
        fwd_b = 2'b01;
      end else if (src_match(id_rs2, id_rs2_vf, id_rs2_use, wb_dest, wb_vf, wb_wreg)) begin
        fwd_b = 2'b10;
      end else begin
        fwd_b = 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// It runs directed scenarios and then randomized traffic.
// All outputs are checked against a behavioural model every cycle.
module tb_pipeline_hazard_ctrl;

  localparam int TO     = 4;
  localparam int CW     = 8;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    id_rs1, id_rs2, ex_dest, mem_dest, wb_dest;
  logic          id_rs1_vf, id_rs2_vf, id_rs1_use, id_rs2_use;
  logic          ex_vf, ex_wreg, ex_rmem, ex_br_taken;
  logic          mem_vf, mem_wreg, mem_rmem, mem_wmem;
  logic          wb_vf, wb_wreg, mem_ack;
  logic          mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_bubble, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_vf(id_rs1_vf), .id_rs2_vf(id_rs2_vf),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_dest(ex_dest), .ex_vf(ex_vf), .ex_wreg(ex_wreg), .ex_rmem(ex_rmem),
    .ex_br_taken(ex_br_taken),
    .mem_dest(mem_dest), .mem_vf(mem_vf), .mem_wreg(mem_wreg), .mem_rmem(mem_rmem),
    .mem_wmem(mem_wmem),
    .wb_dest(wb_dest), .wb_vf(wb_vf), .wb_wreg(wb_wreg),
    .mem_ack(mem_ack), .mem_req(mem_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int req_seen = 0;

  // Reference model state: access phase, cycles spent waiting, sticky error, stall count.
  bit m_wait, m_done, m_err;
  int m_waited, m_stalls;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Unified register number: scalars 0..15, vectors 16..31; number 0 is the zero register.
  function automatic int reg_num(input logic [3:0] idx, input logic vf);
    return vf ? 16 + int'(idx) : int'(idx);
  endfunction

  function automatic bit hits(input logic [3:0] s, input logic svf, input logic use_s,
                              input logic [3:0] xd, input logic xvf, input logic xw);
    int sid;
    sid = reg_num(s, svf);
    return use_s && xw && (sid == reg_num(xd, xvf)) && (sid != 0);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_done = 0; m_err = 0; m_waited = 0; m_stalls = 0;
  endtask

  function automatic logic [1:0] pick_fwd(input logic [3:0] s, input logic svf, input logic use_s);
    if (hits(s, svf, use_s, mem_dest, mem_vf, mem_wreg) && !mem_rmem) return 2'b01;
    if (hits(s, svf, use_s, wb_dest, wb_vf, wb_wreg)) return 2'b10;
    return 2'b00;
  endfunction

  // Check every output one half-cycle before the edge, then advance the model at the edge.
  task automatic step();
    bit         frz, lu, mem_op;
    logic [6:0] ctl;
    logic [1:0] fa, fb;
    @(negedge clk);
    if (rst) model_reset();
    mem_op = mem_rmem || mem_wmem;
    frz = !rst && (m_wait || (!m_done && mem_op));
    lu  = ex_rmem && (hits(id_rs1, id_rs1_vf, id_rs1_use, ex_dest, ex_vf, ex_wreg) ||
                      hits(id_rs2, id_rs2_vf, id_rs2_use, ex_dest, ex_vf, ex_wreg));
    if (rst)              ctl = 7'b1111100;
    else if (frz)         ctl = 7'b0000000;
    else if (ex_br_taken) ctl = 7'b1111111;
    else if (lu)          ctl = 7'b0011101;
    else                  ctl = 7'b1111100;
    fa = rst ? 2'b00 : pick_fwd(id_rs1, id_rs1_vf, id_rs1_use);
    fb = rst ? 2'b00 : pick_fwd(id_rs2, id_rs2_vf, id_rs2_use);
    check_val("ctl", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble}),
              32'(ctl));
    check_val("fwd_a", 32'(fwd_a), 32'(fa));
    check_val("fwd_b", 32'(fwd_b), 32'(fb));
    check_val("mem_req", 32'(mem_req), 32'(m_wait));
    check_val("mem_err", 32'(mem_err), 32'(m_err));
    check_val("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
    if (mem_req === 1'b1) req_seen++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if ((frz || (lu && !ex_br_taken)) && m_stalls < SATMAX) m_stalls++;
      if (m_done) begin
        m_done = 0;
      end else if (m_wait) begin
        if (mem_ack) begin
          m_wait = 0; m_done = 1;
        end else if (m_waited + 1 == TO) begin
          m_err = 1; m_wait = 0; m_done = 1;
        end else begin
          m_waited++;
        end
      end else if (mem_op) begin
        m_wait = 1; m_waited = 0;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_vf = 1'b0; id_rs2_vf = 1'b0;
    id_rs1_use = 1'b0; id_rs2_use = 1'b0;
    ex_dest = 4'd0; ex_vf = 1'b0; ex_wreg = 1'b0; ex_rmem = 1'b0; ex_br_taken = 1'b0;
    mem_dest = 4'd0; mem_vf = 1'b0; mem_wreg = 1'b0; mem_rmem = 1'b0; mem_wmem = 1'b0;
    wb_dest = 4'd0; wb_vf = 1'b0; wb_wreg = 1'b0; mem_ack = 1'b0;
  endtask

  int s0;

  // Directed scenarios followed by randomized traffic.
  initial begin
    model_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    check_val("reset_mem_req", 32'(mem_req), 32'd0);
    check_val("reset_pc_en", 32'(pc_en), 32'd1);
    step(); step();
    rst = 1'b0;

    // Forwarding: vector V3 in MEM and WB, ID reads V3.
    mem_vf = 1'b1; mem_wreg = 1'b1; mem_dest = 4'd3;
    wb_vf = 1'b1; wb_wreg = 1'b1; wb_dest = 4'd3;
    id_rs1 = 4'd3; id_rs1_vf = 1'b1; id_rs1_use = 1'b1;
    step();
    check_val("fwd_v3_mem", 32'(fwd_a), 32'd1);
    id_rs1_vf = 1'b0;
    step();
    check_val("fwd_s3_none", 32'(fwd_a), 32'd0);
    wb_vf = 1'b0; wb_dest = 4'd0; id_rs2 = 4'd0; id_rs2_vf = 1'b0; id_rs2_use = 1'b1;
    step();
    check_val("fwd_r0_none", 32'(fwd_b), 32'd0);

    // Load-use on S5, then the load reaches WB.
    clear_inputs();
    ex_dest = 4'd5; ex_wreg = 1'b1; ex_rmem = 1'b1;
    id_rs1 = 4'd5; id_rs1_use = 1'b1;
    #1;
    check_val("lu_bubble", 32'({pc_en, ifid_en, idex_bubble}), 32'(3'b001));
    step();
    check_val("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    ex_wreg = 1'b0; ex_rmem = 1'b0; wb_dest = 4'd5; wb_wreg = 1'b1;
    step();
    check_val("lu_fwd_wb", 32'(fwd_a), 32'd2);

    // Vector load in MEM, ack in the 4th wait cycle.
    clear_inputs();
    mem_rmem = 1'b1; mem_vf = 1'b1; mem_dest = 4'd2; mem_wreg = 1'b1;
    s0 = int'(stall_cycles);
    req_seen = 0;
    repeat (4) step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    check_val("done_enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(5'b11111));
    step();
    mem_rmem = 1'b0;
    step();
    check_val("vload_req_cycles", 32'(req_seen), 32'd4);
    check_val("vload_stalls", 32'(int'(stall_cycles) - s0), 32'd5);

    // Timeout: ack never comes.
    clear_inputs();
    mem_wmem = 1'b1;
    req_seen = 0;
    repeat (1 + TO) step();
    check_val("timeout_err", 32'(mem_err), 32'd1);
    step();
    mem_wmem = 1'b0;
    repeat (2) step();
    check_val("timeout_req_cycles", 32'(req_seen), 32'd4);
    check_val("timeout_err_sticky", 32'(mem_err), 32'd1);
    check_val("timeout_idle", 32'(mem_req), 32'd0);

    // Branch with simultaneous load-use.
    clear_inputs();
    ex_dest = 4'd7; ex_vf = 1'b1; ex_wreg = 1'b1; ex_rmem = 1'b1;
    id_rs2 = 4'd7; id_rs2_vf = 1'b1; id_rs2_use = 1'b1; ex_br_taken = 1'b1;
    #1;
    check_val("br_lu", 32'({ifid_flush, idex_bubble, pc_en}), 32'(3'b111));
    step();
    // The same branch arrives while a memory access is outstanding.
    mem_rmem = 1'b1;
    step();
    check_val("br_wait_noflush", 32'(ifid_flush), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    check_val("br_done_flush", 32'(ifid_flush), 32'd1);
    step();
    mem_rmem = 1'b0;
    step();

    // Reset asserted in the middle of a wait.
    clear_inputs();
    mem_wmem = 1'b1;
    step();
    check_val("midwait_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_val("midwait_rst_req", 32'(mem_req), 32'd0);
    step();
    rst = 1'b0;
    clear_inputs();
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 4'($urandom_range(0, 3)); id_rs2 = 4'($urandom_range(0, 3));
      id_rs1_vf = 1'($urandom_range(0, 1)); id_rs2_vf = 1'($urandom_range(0, 1));
      id_rs1_use = 1'($urandom_range(0, 1)); id_rs2_use = 1'($urandom_range(0, 1));
      ex_dest = 4'($urandom_range(0, 3)); ex_vf = 1'($urandom_range(0, 1));
      ex_wreg = 1'($urandom_range(0, 1)); ex_rmem = ($urandom_range(0, 2) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mem_dest = 4'($urandom_range(0, 3)); mem_vf = 1'($urandom_range(0, 1));
      mem_wreg = 1'($urandom_range(0, 1));
      mem_rmem = ($urandom_range(0, 3) == 0);
      mem_wmem = !mem_rmem && ($urandom_range(0, 5) == 0);
      wb_dest = 4'($urandom_range(0, 3)); wb_vf = 1'($urandom_range(0, 1));
      wb_wreg = 1'($urandom_range(0, 1));
      mem_ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    // Drive the stall counter into saturation with endless timed-out accesses.
    clear_inputs();
    mem_rmem = 1'b1;
    repeat (400) step();
    check_val("stall_saturate", 32'(stall_cycles), 32'(SATMAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
